// File: rtl/vga_varredura_pkg.sv
// Shared VGA 640x480@60Hz timing defaults and scan-stage types for the raster
// scanner, pixel source and game controllers.
package vga_varredura_pkg;

  localparam int unsigned H_VIS_DEF  = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_VIS_DEF  = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;

  localparam int unsigned H_TOTAL_DEF  = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF  = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned N_PIXELS_DEF = H_VIS_DEF * V_VIS_DEF;

  // Fetch-stage flags; 1 = active, independent of the pin polarity.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } scan_flags_t;

  localparam int unsigned SCAN_FLAGS_W = $bits(scan_flags_t);

endpackage

// File: rtl/vga_varredura_atraso_linha.sv
// Tick-enabled shift register with async clear; DEPTH=0 is a plain pass-through.
module atraso_linha
  import vga_varredura_pkg::*;
#(
  parameter int unsigned WIDTH = SCAN_FLAGS_W,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sr <= '{default: '0};
      end else if (en) begin
        sr[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_varredura.sv
// Raster scanner and VGA output stage: counters, linear address, sync generation
// and a registered RGB output aligned to the pixel source's read latency.
module vga_varredura
  import vga_varredura_pkg::*;
#(
  parameter int unsigned H_VIS    = H_VIS_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_VIS    = V_VIS_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned READ_LAT = 1,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] data_in,
  output logic [18:0] endereco,
  output logic        pixel_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_C   = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_C   = 10'(V_VIS);
  localparam logic [9:0]  HS_START  = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [18:0] ADDR_LAST = 19'(H_VIS * V_VIS - 1);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  scan_flags_t      flags_f;
  scan_flags_t      flags_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                      div <= div + 1'b1;
  end

  assign pixel_tick = !reset && (div == DIV_LAST);

  always_comb begin
    flags_f     = '0;
    flags_f.vis = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    flags_f.hs  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    flags_f.vs  = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  assign frame_start = pixel_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Address advances only on visible fetches, so it always names the next
  // visible pixel without needing y*H_VIS+x.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      endereco <= '0;
    end else if (pixel_tick) begin
      if (flags_f.vis) endereco <= (endereco == ADDR_LAST) ? '0 : endereco + 1'b1;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  atraso_linha #(
    .WIDTH (SCAN_FLAGS_W),
    .DEPTH (READ_LAT)
  ) u_atraso (
    .clk   (clk),
    .reset (reset),
    .en    (pixel_tick),
    .d     (flags_f),
    .q     (flags_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_on <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      rgb      <= '0;
    end else if (pixel_tick) begin
      video_on <= flags_d.vis;
      hsync    <= flags_d.hs ? SYNC_POL : ~SYNC_POL;
      vsync    <= flags_d.vs ? SYNC_POL : ~SYNC_POL;
      rgb      <= flags_d.vis ? data_in : '0;
    end
  end

endmodule
